// File: rtl/id_scoreboard_if.sv
// Decode-stage operand/hazard bundle between if_id/id_ex glue and id_scoreboard.
`default_nettype none

interface id_scoreboard_if #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
);
  logic                      rs1_read_i;
  logic [REG_AW-1:0]         rs1_addr_i;
  logic                      rs2_read_i;
  logic [REG_AW-1:0]         rs2_addr_i;
  logic [XLEN-1:0]           rs1_data_i;
  logic [XLEN-1:0]           rs2_data_i;
  logic [NUM_FWD-1:0]        fwd_wen_i;
  logic [NUM_FWD*REG_AW-1:0] fwd_addr_i;
  logic [NUM_FWD*XLEN-1:0]   fwd_data_i;
  logic                      issue_vld_i;
  logic                      issue_wen_i;
  logic [REG_AW-1:0]         issue_rd_i;
  logic                      issue_long_i;
  logic                      wb_vld_i;
  logic [REG_AW-1:0]         wb_rd_i;
  logic                      flush_i;
  logic [XLEN-1:0]           op1_o;
  logic [XLEN-1:0]           op2_o;
  logic                      hold_flag_o;
  logic                      busy_o;
  logic                      err_o;

  modport master (
    output rs1_read_i, rs1_addr_i, rs2_read_i, rs2_addr_i, rs1_data_i, rs2_data_i,
    output fwd_wen_i, fwd_addr_i, fwd_data_i,
    output issue_vld_i, issue_wen_i, issue_rd_i, issue_long_i,
    output wb_vld_i, wb_rd_i, flush_i,
    input  op1_o, op2_o, hold_flag_o, busy_o, err_o
  );

  modport slave (
    input  rs1_read_i, rs1_addr_i, rs2_read_i, rs2_addr_i, rs1_data_i, rs2_data_i,
    input  fwd_wen_i, fwd_addr_i, fwd_data_i,
    input  issue_vld_i, issue_wen_i, issue_rd_i, issue_long_i,
    input  wb_vld_i, wb_rd_i, flush_i,
    output op1_o, op2_o, hold_flag_o, busy_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/id_scoreboard.sv
// Decode-stage scoreboard: per-register pending counters for long writes,
// prioritised operand bypass, and RAW/WAW/saturation hold generation.
`default_nettype none

module id_scoreboard #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int MAX_PEND = 3
) (
  input  logic            clk,
  input  logic            rstn,
  id_scoreboard_if.slave  bus
);

  localparam int            CW       = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] PEND_TOP = CW'(MAX_PEND);

  logic [CW-1:0] pend_q [REG_NUM];
  logic [CW-1:0] pend_d [REG_NUM];
  logic          err_q, err_d;

  logic [XLEN-1:0] op1, op2;
  logic            hit1, hit2;
  logic            raw1, raw2, waw, sat, hold, fire, busy;

  // Walk channels oldest-first so the youngest matching stage wins.
  always_comb begin
    op1  = bus.rs1_data_i;
    op2  = bus.rs2_data_i;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (bus.fwd_wen_i[k] && bus.fwd_addr_i[k*REG_AW +: REG_AW] == bus.rs1_addr_i) begin
        hit1 = 1'b1;
        op1  = bus.fwd_data_i[k*XLEN +: XLEN];
      end
      if (bus.fwd_wen_i[k] && bus.fwd_addr_i[k*REG_AW +: REG_AW] == bus.rs2_addr_i) begin
        hit2 = 1'b1;
        op2  = bus.fwd_data_i[k*XLEN +: XLEN];
      end
    end
    if (!bus.rs1_read_i || bus.rs1_addr_i == '0) op1 = '0;
    if (!bus.rs2_read_i || bus.rs2_addr_i == '0) op2 = '0;
  end

  always_comb begin
    raw1 = bus.rs1_read_i && (bus.rs1_addr_i != '0) && (pend_q[bus.rs1_addr_i] != '0) && !hit1;
    raw2 = bus.rs2_read_i && (bus.rs2_addr_i != '0) && (pend_q[bus.rs2_addr_i] != '0) && !hit2;
    waw  = bus.issue_wen_i && (bus.issue_rd_i != '0) && (pend_q[bus.issue_rd_i] != '0)
           && !bus.issue_long_i;
    sat  = bus.issue_wen_i && bus.issue_long_i && (bus.issue_rd_i != '0)
           && (pend_q[bus.issue_rd_i] == PEND_TOP);
    hold = !rstn && bus.issue_vld_i && !bus.flush_i && (raw1 || raw2 || waw || sat);
    fire = bus.issue_vld_i && !hold && !bus.flush_i && bus.issue_wen_i
           && bus.issue_long_i && (bus.issue_rd_i != '0);
  end

  // A retire against an empty counter is flagged but never underflows.
  always_comb begin
    err_d = err_q;
    busy  = 1'b0;
    for (int r = 0; r < REG_NUM; r++) begin
      pend_d[r] = pend_q[r];
      busy      = busy | (pend_q[r] != '0);
    end
    pend_d[0] = '0;
    if (bus.wb_vld_i && bus.wb_rd_i != '0 && pend_q[bus.wb_rd_i] == '0) err_d = 1'b1;
    for (int r = 1; r < REG_NUM; r++) begin
      logic inc, dec;
      inc = fire && (bus.issue_rd_i == REG_AW'(r));
      dec = bus.wb_vld_i && (bus.wb_rd_i == REG_AW'(r)) && (pend_q[r] != '0);
      if (inc && !dec)      pend_d[r] = pend_q[r] + CW'(1);
      else if (dec && !inc) pend_d[r] = pend_q[r] - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int r = 0; r < REG_NUM; r++) pend_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < REG_NUM; r++) pend_q[r] <= pend_d[r];
      err_q <= err_d;
    end
  end

  assign bus.op1_o       = op1;
  assign bus.op2_o       = op2;
  assign bus.hold_flag_o = hold;
  assign bus.busy_o      = busy && !rstn;
  assign bus.err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard.
`default_nettype none

module tb_id_scoreboard;
  localparam int XLEN = 32, REG_AW = 5, NUM_FWD = 2;

  logic clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_scoreboard_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) bus ();

  id_scoreboard #(.XLEN(XLEN), .REG_NUM(32), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .MAX_PEND(3))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.rs1_read_i = 0; bus.rs1_addr_i = 0; bus.rs2_read_i = 0; bus.rs2_addr_i = 0;
    bus.rs1_data_i = 0; bus.rs2_data_i = 0;
    bus.fwd_wen_i = 0; bus.fwd_addr_i = 0; bus.fwd_data_i = 0;
    bus.issue_vld_i = 0; bus.issue_wen_i = 0; bus.issue_rd_i = 0; bus.issue_long_i = 0;
    bus.wb_vld_i = 0; bus.wb_rd_i = 0; bus.flush_i = 0;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    bus.issue_vld_i = 1; bus.issue_wen_i = 1; bus.issue_long_i = 1; bus.issue_rd_i = rd;
  endtask

  initial begin
    clr();
    rstn = 1;
    step(); step();
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_err",  32'(bus.err_o), 0);
    chk("rst_hold", 32'(bus.hold_flag_o), 0);
    rstn = 0;

    // Long write to x5, then a RAW read with no bypass stalls.
    issue_long(5); #1;
    chk("issue5_hold", 32'(bus.hold_flag_o), 0);
    step();
    clr();
    bus.issue_vld_i = 1; bus.rs1_read_i = 1; bus.rs1_addr_i = 5; bus.rs1_data_i = 32'h1234; #1;
    chk("raw5_hold", 32'(bus.hold_flag_o), 1);
    chk("raw5_busy", 32'(bus.busy_o), 1);
    chk("raw5_op1_rf", bus.op1_o, 32'h1234);

    // Retire with bypass on ch1 releases immediately.
    bus.fwd_wen_i = 2'b10; bus.fwd_addr_i = {5'd5, 5'd0}; bus.fwd_data_i = {32'hDEADBEEF, 32'h0};
    bus.wb_vld_i = 1; bus.wb_rd_i = 5; #1;
    chk("fwd5_hold", 32'(bus.hold_flag_o), 0);
    chk("fwd5_op1", bus.op1_o, 32'hDEADBEEF);
    step();
    bus.fwd_wen_i = 0; bus.wb_vld_i = 0; #1;
    chk("ret5_busy", 32'(bus.busy_o), 0);
    chk("ret5_hold", 32'(bus.hold_flag_o), 0);

    // Bypass priority and x0.
    clr();
    bus.fwd_wen_i = 2'b11; bus.fwd_addr_i = {5'd7, 5'd7}; bus.fwd_data_i = {32'h22, 32'h11};
    bus.rs2_read_i = 1; bus.rs2_addr_i = 7; bus.rs2_data_i = 32'h99; #1;
    chk("prio_op2", bus.op2_o, 32'h11);
    bus.fwd_addr_i = {5'd7, 5'd0}; bus.fwd_data_i = {32'h22, 32'h55};
    bus.rs1_read_i = 1; bus.rs1_addr_i = 0; bus.rs1_data_i = 32'h77; #1;
    chk("x0_op1", bus.op1_o, 32'h0);
    chk("ch1_op2", bus.op2_o, 32'h22);
    bus.rs2_read_i = 0; #1;
    chk("noread_op2", bus.op2_o, 32'h0);

    // Saturate x3.
    clr();
    issue_long(3); step(); step(); step();
    #1;
    chk("sat_hold", 32'(bus.hold_flag_o), 1);
    bus.wb_vld_i = 1; bus.wb_rd_i = 3; #1;
    chk("sat_wb_hold", 32'(bus.hold_flag_o), 1);
    step();
    bus.wb_vld_i = 0; #1;
    chk("sat_accept", 32'(bus.hold_flag_o), 0);
    step();
    chk("sat_again", 32'(bus.hold_flag_o), 1);

    // WAW on x9 and flush.
    clr();
    issue_long(9); step();
    bus.issue_long_i = 0; #1;
    chk("waw_hold", 32'(bus.hold_flag_o), 1);
    bus.flush_i = 1; #1;
    chk("waw_flush", 32'(bus.hold_flag_o), 0);
    step();
    bus.flush_i = 0; #1;
    chk("waw_kept", 32'(bus.hold_flag_o), 1);

    // Retire without bypass clears stall one cycle later.
    clr();
    bus.issue_vld_i = 1; bus.rs1_read_i = 1; bus.rs1_addr_i = 9;
    bus.wb_vld_i = 1; bus.wb_rd_i = 9; #1;
    chk("ret9_same", 32'(bus.hold_flag_o), 1);
    step();
    bus.wb_vld_i = 0; #1;
    chk("ret9_next", 32'(bus.hold_flag_o), 0);

    // Error flag.
    clr();
    bus.wb_vld_i = 1; bus.wb_rd_i = 0; step();
    chk("wb_x0_err", 32'(bus.err_o), 0);
    bus.wb_rd_i = 4; step();
    chk("wb4_err", 32'(bus.err_o), 1);
    clr(); step();
    chk("err_sticky", 32'(bus.err_o), 1);

    // Reset mid-operation.
    issue_long(2); step(); step();
    clr();
    bus.issue_vld_i = 1; bus.rs1_read_i = 1; bus.rs1_addr_i = 2; #1;
    chk("pre_rst_hold", 32'(bus.hold_flag_o), 1);
    rstn = 1; #1;
    chk("in_rst_hold", 32'(bus.hold_flag_o), 0);
    chk("in_rst_busy", 32'(bus.busy_o), 0);
    chk("in_rst_err", 32'(bus.err_o), 1);
    step();
    rstn = 0; #1;
    chk("post_rst_err", 32'(bus.err_o), 0);
    chk("post_rst_busy", 32'(bus.busy_o), 0);
    chk("post_rst_hold", 32'(bus.hold_flag_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Parametrised successor to the decode-stage hazard/forwarding logic.
- Tracks outstanding long-latency register writes (loads, mul/div) in a per-register pending-counter scoreboard.
- Selects forwarded or register-file operands from NUM_FWD prioritised bypass channels.
- Raises a pipeline hold on RAW, WAW or counter-saturation hazards. Sits between the if_id register and id_ex, beside the regs file.

Parameters:
XLEN, 32, data width of operands and forwarded data
REG_NUM, 32, number of architectural registers (register 0 is hardwired zero)
REG_AW, 5, register address width, must equal clog2(REG_NUM)
NUM_FWD, 2, number of bypass channels; index 0 is the youngest stage and has the highest priority
MAX_PEND, 3, maximum outstanding long writes per register; counter width is clog2(MAX_PEND+1)

Ports:
clk  in  1  clock
rstn  in  1  synchronous, active-high reset (1 = reset)
rs1_read_i  in  1  decoded instruction reads rs1
rs1_addr_i  in  REG_AW  rs1 index
rs2_read_i  in  1  decoded instruction reads rs2
rs2_addr_i  in  REG_AW  rs2 index
rs1_data_i  in  XLEN  register-file rs1 data
rs2_data_i  in  XLEN  register-file rs2 data
fwd_wen_i  in  NUM_FWD  channel k carries valid write data this cycle
fwd_addr_i  in  NUM_FWD*REG_AW  channel k destination; slice k = [k*REG_AW +: REG_AW]
fwd_data_i  in  NUM_FWD*XLEN  channel k data
issue_vld_i  in  1  decoded instruction requests issue to id_ex
issue_wen_i  in  1  issuing instruction writes rd
issue_rd_i  in  REG_AW  destination of issuing instruction
issue_long_i  in  1  issuing instruction is long-latency (load, mul/div)
wb_vld_i  in  1  a long-latency write retires this cycle
wb_rd_i  in  REG_AW  destination of the retiring long write
flush_i  in  1  squash the instruction currently in decode
op1_o  out  XLEN  resolved rs1 operand
op2_o  out  XLEN  resolved rs2 operand
hold_flag_o  out  1  stall request to ctrl
busy_o  out  1  any pending counter is non-zero
err_o  out  1  sticky: wb_vld_i seen for a register whose counter is 0

Behaviour:
- State: pend[r], one counter per register r in 1..REG_NUM-1; pend[0] is constant 0. Also the sticky err flag.
- Reset (rstn=1 at a clk edge): all pend cleared, err_o=0.
  - Combinational outputs during reset: hold_flag_o=0, busy_o=0. op1_o/op2_o follow the operand rules below.
- Operand resolution for rsN (combinational, zero latency):
  - rsN_read_i=0 or addr=0 -> 0.
  - Else the lowest k with fwd_wen_i[k]=1 and fwd_addr k == addr -> fwd_data k.
  - Else -> rsN_data_i.
- raw_N = rsN_read_i & addr!=0 & pend[addr]!=0 & no fwd channel matches addr.
  - A matching fwd channel means the data is available, so there is no stall even while the register is still pending.
- waw = issue_wen_i & issue_rd_i!=0 & pend[issue_rd_i]!=0 & ~issue_long_i. This prevents a short write from overtaking an outstanding long write.
- sat = issue_wen_i & issue_long_i & issue_rd_i!=0 & pend[issue_rd_i]==MAX_PEND.
- hold_flag_o = issue_vld_i & ~flush_i & (raw_1 | raw_2 | waw | sat).
- fire = issue_vld_i & ~hold_flag_o & ~flush_i & issue_wen_i & issue_long_i & issue_rd_i!=0.
- Counter update at the clk edge, for rd = issue_rd_i:
  - fire only -> pend[rd]+1.
  - wb_vld_i only, pend[wb_rd_i]>0 -> pend[wb_rd_i]-1.
  - fire and wb_vld_i on the same register -> unchanged.
  - fire and wb_vld_i on different registers -> both updates apply.
  - wb_vld_i with wb_rd_i=0 -> ignored.
  - wb_vld_i with pend==0 -> counter stays 0 and err_o is set (sticky until reset).
- Latency: an issue is visible in hold_flag_o one cycle later. A retire clears the stall one cycle later, or in the same cycle if the writer also presents its data on a fwd channel.
- Retiring units must drive a fwd channel in the same cycle as wb_vld_i.
- flush_i has no effect on the counters. Already-issued long operations still retire.
- busy_o = OR over all pend, registered-state based.

Test Plan:
- Reset, then issue long write x5 (issue_long_i=1). Next cycle, decode reads rs1=5 with no fwd -> hold_flag_o=1, pend[5]=1, busy_o=1.
- pend[5]=1, fwd_wen_i[1]=1, addr 5, data 0xDEADBEEF, wb_vld_i=1 rd 5 -> hold_flag_o=0, op1_o=0xDEADBEEF. Next cycle pend[5]=0, busy_o=0.
- fwd ch0 and ch1 both target x7 with 0x11 and 0x22, rs2=7 -> op2_o=0x11. rs1=0 with fwd to x0 -> op1_o=0.
- Three long issues to x3 (MAX_PEND=3), then a fourth -> hold_flag_o=1. Same cycle wb_vld_i rd 3 -> still held. Next cycle issue accepted, pend[3]=3.
- pend[9]=1, short issue to x9 -> hold (WAW). Same stimulus with flush_i=1 -> hold_flag_o=0, pend[9]=1.
- wb_vld_i rd 4 with pend[4]=0 -> err_o=1, stays set. Assert rstn=1 mid-operation with pend[2]=2 -> all counters 0, err_o=0 next cycle.
